// File: rtl/rr_onehot_arbiter.sv
// rr_onehot_arbiter: round-robin one-hot arbiter with hold timeout and a guard cycle between grants
module rr_onehot_arbiter #(
    parameter int NUM_REQ  = 16,
    parameter int MAX_HOLD = 8,
    localparam int W  = $clog2(NUM_REQ),
    localparam int HW = $clog2(MAX_HOLD) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               release_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [W-1:0]       gnt_idx_o,
    output logic               gnt_valid_o,
    output logic               preempt_o
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t        state;
    logic [W-1:0]  ptr;
    logic [HW-1:0] hold_cnt;
    logic [W-1:0]  sel;
    logic [W-1:0]  c;
    logic          owner_req;
    logic          done;
    always_comb begin
        sel = '0;
        c   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            c = ptr + W'(k);
            sel = req_i[c] ? c : sel;
        end
    end
    assign owner_req = req_i[gnt_idx_o];
    assign done      = !owner_req || release_i || hold_cnt == HW'(MAX_HOLD - 1);
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            gnt_o       <= '0;
            gnt_idx_o   <= '0;
            gnt_valid_o <= 1'b0;
            preempt_o   <= 1'b0;
            ptr         <= '0;
            hold_cnt    <= '0;
        end else if (state == IDLE) begin
            preempt_o <= 1'b0;
            if (|req_i) begin
                state       <= GRANT;
                gnt_idx_o   <= sel;
                gnt_o       <= {{(NUM_REQ-1){1'b0}}, 1'b1} << sel;
                gnt_valid_o <= 1'b1;
                hold_cnt    <= '0;
            end
        end else if (done) begin
            state       <= IDLE;
            gnt_o       <= '0;
            gnt_idx_o   <= '0;
            gnt_valid_o <= 1'b0;
            ptr         <= gnt_idx_o + W'(1);
            preempt_o   <= owner_req && !release_i;
        end else begin
            hold_cnt <= hold_cnt + HW'(1);
        end
    end
endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// tb_rr_onehot_arbiter: directed and random checks of rr_onehot_arbiter against a cycle-level reference model
module tb_rr_onehot_arbiter;
    localparam int N = 16;
    localparam int MH = 8;
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  req_i = '0;
    logic          release_i = 1'b0;
    logic [N-1:0]  gnt_o;
    logic [3:0]    gnt_idx_o;
    logic          gnt_valid_o;
    logic          preempt_o;
    int            checks = 0;
    int            errors = 0;
    bit            cmp_en = 1'b0;
    int            m_owner = -1;
    int            m_held = 0;
    int            m_ptr = 0;
    bit            m_pre = 1'b0;
    rr_onehot_arbiter #(.NUM_REQ(N), .MAX_HOLD(MH)) dut (
        .clk(clk), .reset(reset), .req_i(req_i), .release_i(release_i),
        .gnt_o(gnt_o), .gnt_idx_o(gnt_idx_o), .gnt_valid_o(gnt_valid_o), .preempt_o(preempt_o)
    );
    always #5 clk = ~clk;
    function automatic void step(input bit rst, input logic [N-1:0] req, input bit rel,
                                 inout int owner, inout int held, inout int ptr, inout bit pre);
        if (rst) begin
            owner = -1; held = 0; ptr = 0; pre = 0;
        end else if (owner < 0) begin
            pre = 0;
            for (int off = 0; off < N && owner < 0; off++)
                if (req[(ptr + off) % N]) owner = (ptr + off) % N;
            held = 1;
        end else if (!req[owner] || rel || held == MH) begin
            pre = req[owner] && !rel;
            ptr = (owner + 1) % N;
            owner = -1;
        end else begin
            held++;
        end
    endfunction
    always @(posedge clk) begin
        int o, h, p;
        bit q;
        o = m_owner; h = m_held; p = m_ptr; q = m_pre;
        step(reset, req_i, release_i, o, h, p, q);
        m_owner <= o; m_held <= h; m_ptr <= p; m_pre <= q;
    end
    always @(negedge clk) begin
        logic [N-1:0] eg;
        if (cmp_en) begin
            eg = (m_owner < 0) ? '0 : (N'(1) << m_owner);
            checks += 4;
            if (gnt_o !== eg) begin errors++; $display("FAIL model gnt_o got %h want %h t=%0t", gnt_o, eg, $time); end
            if (gnt_idx_o !== 4'((m_owner < 0) ? 0 : m_owner)) begin errors++; $display("FAIL model gnt_idx_o got %0d want %0d t=%0t", gnt_idx_o, (m_owner < 0) ? 0 : m_owner, $time); end
            if (gnt_valid_o !== (m_owner >= 0)) begin errors++; $display("FAIL model gnt_valid_o got %b want %b t=%0t", gnt_valid_o, m_owner >= 0, $time); end
            if (preempt_o !== m_pre) begin errors++; $display("FAIL model preempt_o got %b want %b t=%0t", preempt_o, m_pre, $time); end
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h t=%0t", name, act, exp, $time);
        end
    endtask
    task automatic do_reset();
        reset = 1'b1; req_i = '0; release_i = 1'b0;
        tick();
        reset = 1'b0;
    endtask
    initial begin
        int cnt;
        req_i = 16'hFFFF;
        tick();
        cmp_en = 1'b1;
        tick();
        chk("reset_gnt", 32'(gnt_o), 0);
        chk("reset_valid_pre", {30'd0, gnt_valid_o, preempt_o}, 0);
        reset = 1'b0;
        tick();
        chk("first_after_reset_idx", 32'(gnt_idx_o), 0);
        chk("first_after_reset_gnt", 32'(gnt_o), 32'h0001);
        do_reset();
        req_i = 16'h0001;
        tick();
        chk("single_gnt", 32'(gnt_o), 32'h0001);
        tick(); tick();
        req_i = '0;
        tick();
        chk("single_drop_gnt", 32'(gnt_o), 0);
        chk("single_drop_pre", 32'(preempt_o), 0);
        do_reset();
        req_i = 16'h8001;
        for (int r = 0; r < 4; r++) begin
            tick();
            chk("fair_idx", 32'(gnt_idx_o), (r % 2) ? 15 : 0);
            tick();
            chk("fair_still", 32'(gnt_valid_o), 1);
            release_i = 1'b1;
            tick();
            release_i = 1'b0;
            chk("fair_guard", 32'(gnt_o), 0);
        end
        do_reset();
        req_i = 16'h0010;
        tick();
        cnt = 0;
        while (gnt_o == 16'h0010 && cnt < 20) begin cnt++; tick(); end
        chk("timeout_len", 32'(cnt), MH);
        chk("timeout_guard_gnt", 32'(gnt_o), 0);
        chk("timeout_pre", 32'(preempt_o), 1);
        tick();
        chk("timeout_regrant", 32'(gnt_idx_o), 4);
        chk("timeout_regrant_pre", 32'(preempt_o), 0);
        do_reset();
        req_i = 16'h8000;
        tick();
        chk("wrap_15", 32'(gnt_idx_o), 15);
        req_i = '0;
        tick();
        req_i = 16'h0006;
        tick();
        chk("wrap_idx1", 32'(gnt_idx_o), 1);
        release_i = 1'b1;
        tick();
        release_i = 1'b0;
        tick();
        chk("wrap_idx2", 32'(gnt_idx_o), 2);
        do_reset();
        req_i = 16'h0020;
        tick();
        chk("mid_idx5", 32'(gnt_idx_o), 5);
        tick(); tick();
        reset = 1'b1;
        tick();
        chk("mid_reset_gnt", 32'(gnt_o), 0);
        chk("mid_reset_pre", 32'(preempt_o), 0);
        reset = 1'b0;
        req_i = 16'h0021;
        tick();
        chk("mid_after_idx0", 32'(gnt_idx_o), 0);
        for (int i = 0; i < 4000; i++) begin
            case ($urandom_range(0, 3))
                0: req_i = N'($urandom);
                1: req_i = N'(1) << $urandom_range(0, N - 1);
                2: req_i = N'($urandom) & N'($urandom) & N'($urandom);
                default: req_i = req_i;
            endcase
            release_i = ($urandom_range(0, 9) < 2);
            reset = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset = 1'b0;
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rr_onehot_arbiter.md
Name: rr_onehot_arbiter

Overview:
- Round-robin arbiter that shares one resource among NUM_REQ requesters.
- Issues a registered one-hot grant and its binary index, so the grant vector can drive the resource muxes or enables directly.
- Enforces a maximum hold time per grant so no requester can starve the others.
- Inserts one guard cycle between consecutive grants for resource turnaround.

Parameters:
- NUM_REQ, 16, number of requesters; power of 2, range 2..16.
- MAX_HOLD, 8, maximum consecutive cycles a single grant may stay asserted; must be at least 1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req_i  input  NUM_REQ  request per requester; level, held while the requester wants the resource.
- release_i  input  1  current owner finished; sampled only while a grant is active.
- gnt_o  output  NUM_REQ  registered one-hot grant; all zero when no grant is active.
- gnt_idx_o  output  $clog2(NUM_REQ)  binary index of the current owner; 0 when gnt_valid_o is 0.
- gnt_valid_o  output  1  high exactly when gnt_o is nonzero.
- preempt_o  output  1  one-cycle pulse marking a grant that was ended by timeout.

Behaviour:
- Reset (synchronous, highest priority):
  - state goes to IDLE.
  - gnt_o=0, gnt_idx_o=0, gnt_valid_o=0, preempt_o=0.
  - Priority pointer ptr=0 and hold counter hold_cnt=0.
  - Reset asserted mid-grant drops the grant on the next edge. No preempt_o pulse is generated.
- State IDLE:
  - If req_i is nonzero, select the first set bit scanning ptr, ptr+1, … NUM_REQ-1, 0, … ptr-1 (modulo NUM_REQ).
  - The selected index loads gnt_idx_o, its one-hot decode loads gnt_o, and gnt_valid_o=1.
  - hold_cnt is set to 0 and the state moves to GRANT.
  - If req_i is zero, stay in IDLE with outputs at 0.
  - Latency: request visible at edge t, grant visible after edge t+1 (one cycle).
- State GRANT (owner = gnt_idx_o):
  - Each cycle, hold_cnt increments.
  - The grant ends when any of these is sampled: req_i[owner]=0, release_i=1, or hold_cnt==MAX_HOLD-1.
  - On end:
    - gnt_o, gnt_idx_o and gnt_valid_o clear on the next edge.
    - ptr is set to (owner+1) mod NUM_REQ, wrapping 15 to 0 for NUM_REQ=16.
    - The state moves to IDLE.
  - Otherwise all outputs hold.
  - A grant with its request continuously held is therefore high for exactly MAX_HOLD cycles.
- Guard cycle:
  - Every grant is followed by at least one IDLE cycle with gnt_o=0.
  - There are no back-to-back grants, even to a different requester.
- preempt_o:
  - Asserted for exactly the one IDLE cycle that follows a grant ended only by timeout, i.e. req_i[owner]=1 and release_i=0 at the ending edge.
  - If release_i or a request drop coincides with the timeout, preempt_o stays 0.
- Request changes:
  - Non-owner bits of req_i are ignored during GRANT.
  - Requests may rise or fall at any time; a pulse that falls before being sampled in IDLE is lost.
- Single requester:
  - A requester that remains the only active one after timeout is re-granted after the guard cycle.
- Outputs:
  - All outputs come straight from registers; there are no combinational paths from input to output.
  - gnt_o is always either zero or exactly one-hot.

Test Plan:
- Reset: assert reset with req_i=16'hFFFF for 2 cycles -> gnt_o=0, gnt_idx_o=0, gnt_valid_o=0, preempt_o=0 throughout; the first grant after reset release goes to index 0.
- Single request: req_i=16'h0001 at edge t -> gnt_o=16'h0001, gnt_idx_o=0, gnt_valid_o=1 after t+1; drop req_i at edge t+3 -> gnt_o=0 after t+4, preempt_o stays 0.
- Fairness: hold req_i=16'h8001 and pulse release_i on the 2nd cycle of each grant -> grant order 0, 15, 0, 15, each lasting 2 cycles, separated by 1 IDLE cycle.
- Timeout: MAX_HOLD=8, hold req_i=16'h0010 -> gnt_o=16'h0010 for exactly 8 cycles, then 1 cycle of gnt_o=0 with preempt_o=1, then re-granted to index 4.
- Pointer wrap: obtain and end a grant to index 15, then present req_i=16'h0006 -> grant goes to index 1, and to index 2 after release.
- Reset mid-grant: assert reset during the 3rd cycle of a grant to index 5 -> outputs 0 on the next edge; a subsequent req_i=16'h0021 is granted to index 0 because the pointer reset to 0.
